// File: rtl/addr_counter_register.sv
// rtl/addr_counter_register.sv - multi-byte address register with byte-lane bus access and up/down counting
//
// Purpose: holds an ADDR_WIDTH-bit address (PC, SP or MAR role). Byte lanes
// are written from and read back onto a shared data bus. The register can be
// parallel-loaded or stepped up/down in place. wrap flags a counter
// overflow/underflow for one cycle.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   CS       chip select; gates WE, OE, INC, DEC, LD_A (not OE_A)
//   SEL      byte lane for WE/OE, 0 = least significant
//   WE       write lane SEL from data
//   OE       drive lane SEL onto data
//   OE_A     drive full register onto address
//   INC/DEC  add/subtract STEP
//   LD_A     parallel load from addr_in
//   addr_in  parallel load value
//   data     shared bidirectional data bus
//   address  tri-stated address bus
//   addr_q   register contents, always driven
//   wrap     registered overflow/underflow flag

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module addr_counter_register #(
    parameter int                                DATA_WIDTH  = `DATA_WIDTH,
    parameter int                                BYTES       = 2,
    parameter int                                SEL_WIDTH   = 1,
    parameter logic [DATA_WIDTH*BYTES-1:0]       RESET_VALUE = '0,
    parameter int                                STEP        = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 CS,
    input  logic [SEL_WIDTH-1:0]                 SEL,
    input  logic                                 WE,
    input  logic                                 OE,
    input  logic                                 OE_A,
    input  logic                                 INC,
    input  logic                                 DEC,
    input  logic                                 LD_A,
    input  logic [DATA_WIDTH*BYTES-1:0]          addr_in,
    inout  wire  [DATA_WIDTH-1:0]                data,
    output logic [DATA_WIDTH*BYTES-1:0]          address,
    output logic [DATA_WIDTH*BYTES-1:0]          addr_q,
    output logic                                 wrap
);

    localparam int ADDR_WIDTH = DATA_WIDTH * BYTES;

    // One extra bit on both operands so the carry/borrow out of the
    // modulo arithmetic falls into the MSB and becomes the wrap flag.
    localparam logic [ADDR_WIDTH:0] STEP_EXT  = (ADDR_WIDTH + 1)'(STEP);
    localparam logic [SEL_WIDTH:0]  BYTES_EXT = (SEL_WIDTH + 1)'(BYTES);

    logic [ADDR_WIDTH-1:0] q_q;
    logic [ADDR_WIDTH-1:0] q_d;
    logic                  wrap_q;
    logic                  wrap_d;

    logic                  sel_ok;
    logic [ADDR_WIDTH:0]   inc_sum;
    logic [ADDR_WIDTH:0]   dec_diff;
    logic [DATA_WIDTH-1:0] lane_rd;
    logic                  data_drive;

    assign sel_ok   = ({1'b0, SEL} < BYTES_EXT);
    assign inc_sum  = {1'b0, q_q} + STEP_EXT;
    assign dec_diff = {1'b0, q_q} - STEP_EXT;

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (CS) begin
            if (LD_A) begin
                q_d = addr_in;
            end else if (WE) begin
                if (sel_ok) begin
                    for (int i = 0; i < BYTES; i++) begin
                        if (SEL == SEL_WIDTH'(i)) begin
                            q_d[i*DATA_WIDTH +: DATA_WIDTH] = data;
                        end
                    end
                end
            end else if (INC && !DEC) begin
                q_d    = inc_sum[ADDR_WIDTH-1:0];
                wrap_d = inc_sum[ADDR_WIDTH];
            end else if (DEC && !INC) begin
                q_d    = dec_diff[ADDR_WIDTH-1:0];
                wrap_d = dec_diff[ADDR_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q    <= RESET_VALUE;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    always_comb begin
        lane_rd = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (SEL == SEL_WIDTH'(i)) begin
                lane_rd = q_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // WE masks OE so the block never drives the bus it is sampling.
    assign data_drive = CS && OE && !WE && sel_ok;

    assign data    = data_drive ? lane_rd : {DATA_WIDTH{1'bz}};
    assign address = OE_A ? q_q : {ADDR_WIDTH{1'bz}};
    assign addr_q  = q_q;
    assign wrap    = wrap_q;

endmodule

// File: doc/addr_counter_register.md
# addr_counter_register

Parametrised, multi-byte address register with built-in up/down counting. It replaces the plain two-byte address register for the program counter, stack pointer and memory address register roles. Each byte lane is loaded from and driven onto the shared data bus. The full address is driven onto the address bus under its own enable, and the register increments or decrements in place so the control unit does not need an ALU pass. A wrap flag reports counter overflow and underflow.

## Interface
- DATA_WIDTH, default `DATA_WIDTH (8): width of one byte lane and of the data bus
- BYTES, default 2: number of byte lanes; ADDR_WIDTH = DATA_WIDTH*BYTES
- SEL_WIDTH, default 1: width of SEL; must satisfy 2**SEL_WIDTH >= BYTES
- RESET_VALUE, default 0: ADDR_WIDTH-bit value loaded on reset
- STEP, default 1: increment/decrement amount, 1..2**DATA_WIDTH-1
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- CS  input  1  chip select; gates WE, OE, INC, DEC, LD_A; does not gate OE_A
- SEL  input  SEL_WIDTH  byte lane for WE/OE; 0 = least significant byte
- WE  input  1  write selected lane from data
- OE  input  1  drive selected lane onto data
- OE_A  input  1  drive full register onto address
- INC  input  1  add STEP
- DEC  input  1  subtract STEP
- LD_A  input  1  parallel load from addr_in
- addr_in  input  ADDR_WIDTH  parallel load value (branch target)
- data  inout  DATA_WIDTH  shared data bus
- address  output  ADDR_WIDTH  tri-stated address bus
- addr_q  output  ADDR_WIDTH  register contents, always driven
- wrap  output  1  registered overflow/underflow flag

## Operation
- State: one ADDR_WIDTH register Q and the wrap flag. No transparent latches; all updates happen on the rising edge of clk.
- Update priority per edge when CS=1:
  - LD_A: Q <= addr_in.
  - else WE: lane SEL of Q <= data; other lanes hold.
  - else INC xor DEC: Q <= Q ± STEP, modulo 2**ADDR_WIDTH.
  - else: hold.
- INC and DEC asserted together: hold, no wrap.
- WE with SEL >= BYTES: no write.
- CS=0: Q holds and data is not driven, whatever WE/OE/INC/DEC/LD_A are doing.
- data is driven with lane SEL of Q when CS & OE & ~WE & (SEL < BYTES); otherwise it is high-Z. Write has priority, so the block never drives the bus it is sampling.
- address = Q when OE_A, else high-Z. addr_q = Q at all times.
- wrap:
  - Set to 1 for exactly one cycle after an INC edge where Q + STEP >= 2**ADDR_WIDTH, or a DEC edge where Q < STEP.
  - 0 after any other edge, including LD_A and WE edges that win priority over a simultaneous INC/DEC.
- Reset (reset=0) at any time, including mid-count or mid-write: Q = RESET_VALUE and wrap = 0 immediately. The data and address drivers follow the new Q combinationally. The first update after release is on the first rising edge with reset=1.

## Timing
- Load, write and count latency is 1 cycle. The new Q is visible on addr_q, address and data right after the edge.
- Output enables (OE, OE_A) are combinational, with zero-cycle latency.
- wrap is registered and asserts in the same cycle the wrapped Q becomes visible.
- Back-to-back INC on consecutive cycles advances by STEP every cycle, with no bubbles.
- Control inputs must be stable around the rising edge. data must be valid at the edge when WE=1.

## Test plan
All scenarios use DATA_WIDTH=8, BYTES=2, STEP=1, RESET_VALUE=16'h0000 unless noted.
- Reset/load:
  - Assert reset=0 mid-count → addr_q=16'h0000 and wrap=0 without waiting for a clock edge.
  - Release, then CS=1, LD_A=1, addr_in=16'h1234 → addr_q=16'h1234 after one edge.
- Byte-lane write/read:
  - WE with SEL=0, data=8'hCD; then WE with SEL=1, data=8'hAB → addr_q=16'hABCD.
  - Then OE with SEL=1 → data=8'hAB. With WE=OE=1 → data stays high-Z.
  - With CS=0 → no change and data stays high-Z.
- Wrap:
  - LD_A 16'hFFFE, then INC for 3 cycles → addr_q=FFFF, 0000, 0001; wrap=0, 1, 0.
  - DEC from 16'h0000 → addr_q=16'hFFFF, wrap=1.
- Priority:
  - LD_A=1 with INC=1 and addr_in=16'h0FFF → addr_q=16'h0FFF, wrap=0.
  - INC=DEC=1 at 16'h0040 → holds at 16'h0040.
  - WE with INC=1 → only the write takes effect.
- Address drive:
  - OE_A=0 → address high-Z. OE_A=1 with CS=0 → address=Q.
  - Parameter sweep BYTES=3 with STEP=4: INC from 24'hFFFFFE → 24'h000002, wrap=1.
  - BYTES=3: WE with SEL=3 → ignored.
